seven_segment_scan_controller: RTL and testbench

Sequencing controller for the two-digit seven-segment display path. It accepts an 8-bit binary value through a valid/ready handshake and converts it to two packed BCD digits with an iterative double-dabble sequence. It then time-multiplexes a single shared BCD-to-seven-segment decoder across the two digit positions at a programmable refresh rate. It sits between the datapath producing numeric results and the board display pins.

---
 rtl/display_pkg.sv | 27 ++
 rtl/BCD_to_seven_segment.sv | 27 ++
 rtl/seven_segment_scan_controller.sv | 99 +++++++++
 tb/tb_seven_segment_scan_controller.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit seven-segment display path.
package display_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    COMMIT
  } state_t;

  localparam int         MAX_DISPLAY   = 99;
  localparam logic [1:0] DIGIT_UNITS   = 2'b01;
  localparam logic [1:0] DIGIT_TENS    = 2'b10;
  localparam int         DD_ITERATIONS = 8;

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  function automatic logic [7:0] dd_adjust(input logic [7:0] bcd);
    bcd_digit_t hi, lo;
    hi = bcd[7:4];
    lo = bcd[3:0];
    if (hi >= 4'd5) hi = hi + 4'd3;
    if (lo >= 4'd5) lo = lo + 4'd3;
    return {hi, lo};
  endfunction

endpackage

// File: rtl/BCD_to_seven_segment.sv
// BCD digit to seven-segment pattern, active-high, segment[6:0] = {a,b,c,d,e,f,g}.
// Codes 10..15 blank the digit.
module BCD_to_seven_segment
  import display_pkg::*;
(
  input  bcd_digit_t bcd,
  output logic [6:0] segment
);

  always_comb begin
    segment = 7'h00;
    case (bcd)
      4'd0: segment = 7'h7E;
      4'd1: segment = 7'h30;
      4'd2: segment = 7'h6D;
      4'd3: segment = 7'h79;
      4'd4: segment = 7'h33;
      4'd5: segment = 7'h5B;
      4'd6: segment = 7'h5F;
      4'd7: segment = 7'h70;
      4'd8: segment = 7'h7F;
      4'd9: segment = 7'h7B;
      default: segment = 7'h00;
    endcase
  end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Binary-to-BCD load/convert/commit sequencer plus two-digit display scanner.
// Optional macro BLANK_LEADING_ZERO_EN blanks the tens digit when it is 0.
module seven_segment_scan_controller
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] value,
  input  logic       load_valid,
  output logic       load_ready,
  output logic       busy,
  output logic [7:0] bcd_value,
  output logic       overflow,
  output logic [6:0] segment,
  output logic [1:0] digit_en
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  state_t     state, state_nxt;
  logic [7:0] bin_q;
  logic [7:0] bcd_q;
  logic [3:0] iter_q;
  logic [CW-1:0] ref_cnt;
  logic       slot;
  bcd_digit_t nibble;

  assign load_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_valid) state_nxt = CONVERT;
      CONVERT: if (iter_q == 4'(DD_ITERATIONS)) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The first CONVERT cycle only sees the freshly captured operand; the
  // eight shift iterations happen on the following edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      iter_q    <= '0;
      bcd_value <= 8'h00;
      overflow  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (load_valid) begin
          bin_q    <= (value > 8'(MAX_DISPLAY)) ? 8'(MAX_DISPLAY) : value;
          overflow <= (value > 8'(MAX_DISPLAY));
          bcd_q    <= '0;
          iter_q   <= '0;
        end
        CONVERT: if (iter_q != 4'(DD_ITERATIONS)) begin
          {bcd_q, bin_q} <= {dd_adjust(bcd_q), bin_q} << 1;
          iter_q         <= iter_q + 4'd1;
        end
        COMMIT: bcd_value <= bcd_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt <= '0;
      slot    <= 1'b0;
    end else if (ref_cnt == CW'(REFRESH_DIV - 1)) begin
      ref_cnt <= '0;
      slot    <= ~slot;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  assign nibble = slot ? bcd_value[7:4] : bcd_value[3:0];

  always_comb begin
    digit_en = slot ? DIGIT_TENS : DIGIT_UNITS;
`ifdef BLANK_LEADING_ZERO_EN
    if (slot && (bcd_value[7:4] == 4'd0)) digit_en = 2'b00;
`else
`endif
  end

  BCD_to_seven_segment u_dec (
    .bcd     (nibble),
    .segment (segment)
  );

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Scoreboard bench: loads push expected commits, a negedge monitor checks them.
module tb_seven_segment_scan_controller;

  typedef struct {
    logic [7:0] bcd;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] value = 8'h00;
  logic       load_valid = 1'b0;
  logic       load_ready, busy, overflow;
  logic [7:0] bcd_value;
  logic [6:0] segment;
  logic [1:0] digit_en;

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb_q[$];

  seven_segment_scan_controller #(.REFRESH_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .busy       (busy),
    .bcd_value  (bcd_value),
    .overflow   (overflow),
    .segment    (segment),
    .digit_en   (digit_en)
  );

  always #5 clk = ~clk;

  // Hand-derived {a..g} patterns for digits 0..9.
  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a busy->idle transition is a commit; pop and compare.
  int   lr_cnt = 0;
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      lr_cnt    = 0;
      busy_prev = 1'b0;
    end else begin
      if (!load_ready) lr_cnt++;
      if (busy_prev && !busy) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_commit: got bcd %0h, no expected entry", bcd_value);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("commit_bcd", bcd_value, e.bcd);
          check("commit_overflow", overflow, e.ovf);
          check("ready_low_cycles", lr_cnt, 10);
        end
        lr_cnt = 0;
      end
      busy_prev = busy;
    end
  end

  task automatic wait_idle(input string name);
    int t = 0;
    while (!load_ready && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    if (!load_ready) check({name, "_timeout"}, 0, 1);
  endtask

  // Drives one load; inputs change 1 time unit after the rising edge.
  task automatic do_load(input logic [7:0] v, input logic [7:0] exp_bcd, input logic exp_ovf);
    exp_t e;
    wait_idle("pre_load");
    e.bcd = exp_bcd;
    e.ovf = exp_ovf;
    sb_q.push_back(e);
    value = v;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    wait_idle("load");
    @(negedge clk);
  endtask

  // Watches the scan for n cycles: slot contents and 4-cycle slot length.
  task automatic scan_check(input logic [7:0] bcd, input int n);
    logic units, prev_units, seen;
    int run;
    logic [1:0] tens_en;
    tens_en = 2'b10;
`ifdef BLANK_LEADING_ZERO_EN
    if (bcd[7:4] == 4'd0) tens_en = 2'b00;
`endif
    seen = 1'b0;
    run = 0;
    prev_units = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      units = (digit_en == 2'b01);
      if (units) begin
        check("scan_units_seg", segment, seg_of(int'(bcd[3:0])));
      end else begin
        check("scan_tens_en", digit_en, tens_en);
        check("scan_tens_seg", segment, seg_of(int'(bcd[7:4])));
      end
      if (i > 0 && units != prev_units) begin
        if (seen) check("scan_slot_len", run, 4);
        seen = 1'b1;
        run = 1;
      end else begin
        run++;
      end
      prev_units = units;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_bcd", bcd_value, 8'h00);
    check("rst_overflow", overflow, 0);
    check("rst_ready", load_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_digit_en", digit_en, 2'b01);
    check("rst_segment", segment, seg_of(0));
    rst = 1'b0;
    // Counter starts at 0: units slot for exactly 4 cycles, then tens.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_units", digit_en, 2'b01);
    end
    @(negedge clk);
    check("post_rst_tens", digit_en, 2'b10);
    @(posedge clk); #1;

    do_load(8'd42, 8'h42, 1'b0);
    check("hold_42", bcd_value, 8'h42);
    scan_check(8'h42, 20);

    @(posedge clk); #1;
    do_load(8'd200, 8'h99, 1'b1);
    check("sat_overflow", overflow, 1);
    @(posedge clk); #1;
    do_load(8'd7, 8'h07, 1'b0);
    check("ovf_cleared", overflow, 0);
    scan_check(8'h07, 20);

    // Load 42, then hold valid with 55 during busy; it must be ignored.
    @(posedge clk); #1;
    begin
      exp_t e;
      e.bcd = 8'h42;
      e.ovf = 1'b0;
      sb_q.push_back(e);
    end
    value = 8'd42;
    load_valid = 1'b1;
    @(posedge clk); #1;
    value = 8'd55;
    repeat (6) begin
      @(posedge clk); #1;
    end
    check("busy_during_ignore", busy, 1);
    load_valid = 1'b0;
    wait_idle("ignore");
    repeat (5) @(negedge clk);
    check("ignore_bcd", bcd_value, 8'h42);

    // Reset during the 4th conversion cycle: no commit afterwards.
    @(posedge clk); #1;
    value = 8'd99;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("pre_abort_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_bcd", bcd_value, 8'h00);
    check("abort_ready", load_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_overflow", overflow, 0);
    check("abort_digit_en", digit_en, 2'b01);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("abort_no_commit", bcd_value, 8'h00);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
